// File: rtl/core_wb_reg_writer.sv
// Writeback driver for the register file's single write port. Single-cycle ALU
// results and buffered long-latency (load/div) results share one write per
// cycle. A 32-entry pending scoreboard tells ID which registers still await a
// long-latency write.
module core_wb_reg_writer #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_addr,
    input  logic [31:0]                   alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [4:0]                    lsu_addr,
    input  logic [31:0]                   lsu_data,
    input  logic                          issue_en,
    input  logic [4:0]                    issue_addr,
    input  logic [4:0]                    chk_0_addr,
    output logic                          chk_0_busy,
    input  logic [4:0]                    chk_1_addr,
    output logic                          chk_1_busy,
    output logic [4:0]                    write_addr,
    output logic [31:0]                   write_data,
    output logic                          write_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       pending_q, pending_d;
    logic              write_en_q, write_en_d;
    logic [4:0]        write_addr_q, write_addr_d;
    logic [31:0]       write_data_q, write_data_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              sel_pop;
    logic              sel_alu;
    entry_t            head;
    logic [4:0]        sel_addr;
    logic [31:0]       sel_data;

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign alu_ready  = !fifo_full;
    assign lsu_ready  = !fifo_full;
    assign head       = mem_q[rd_ptr_q];

    // Push is refused while full, so a push never meets a forced full-FIFO pop.
    assign push    = lsu_valid && !fifo_full;
    assign sel_alu = !fifo_full && alu_valid;
    assign sel_pop = fifo_full || (!alu_valid && !fifo_empty);

    assign sel_addr = sel_pop ? head.addr : alu_addr;
    assign sel_data = sel_pop ? head.data : alu_data;

    assign chk_0_busy = pending_q[chk_0_addr];
    assign chk_1_busy = pending_q[chk_1_addr];

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign fifo_count = count_q;

    // FIFO next state: tail write on push, head advance on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: lsu_addr, data: lsu_data};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (sel_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, sel_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port next state: register 0 items are consumed without a write.
    always_comb begin
        write_en_d   = (sel_pop || sel_alu) && (sel_addr != 5'd0);
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (write_en_d) begin
            write_addr_d = sel_addr;
            write_data_d = sel_data;
        end
    end

    // Scoreboard next state: a pop clears its register, an issue sets (set wins).
    always_comb begin
        pending_d = pending_q;
        if (sel_pop) begin
            pending_d[head.addr] = 1'b0;
        end
        if (issue_en && (issue_addr != 5'd0)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    // FIFO storage; no reset needed since the pointers gate what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_core_wb_reg_writer.sv
// Self-checking bench for core_wb_reg_writer: ALU vector table plus
// hand-written sequences; expected writes queue up in write order and are
// popped whenever the DUT asserts write_en.
module tb_core_wb_reg_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_0_addr, chk_1_addr;
    logic        chk_0_busy, chk_1_busy;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_en;
    logic [1:0]  fifo_count;

    core_wb_reg_writer #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .chk_0_addr (chk_0_addr),
        .chk_0_busy (chk_0_busy),
        .chk_1_addr (chk_1_addr),
        .chk_1_busy (chk_1_busy),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exp_we;
    } alu_vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    alu_vec_t vecs [8];
    wr_t      exp_q [$];
    int       n_vec  = 0;
    int       n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, score any write.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                         write_addr, write_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 32'(write_addr), 32'(e.addr));
                check("wb_data", write_data, e.data);
            end
        end
    endtask

    task automatic issue(input logic [4:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
        tick();
        issue_en   = 1'b0;
    endtask

    task automatic probe(input logic [4:0] a0, input logic [4:0] a1);
        chk_0_addr = a0;
        chk_1_addr = a1;
        #1;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] busy0_all, busy1_all;

        vecs[0] = '{5'd5,  32'h1234_5678, 1'b1};
        vecs[1] = '{5'd31, 32'hFFFF_0000, 1'b1};
        vecs[2] = '{5'd1,  32'h0000_0000, 1'b1};
        vecs[3] = '{5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{5'd17, 32'hA5A5_A5A5, 1'b1};
        vecs[5] = '{5'd0,  32'h0000_0001, 1'b0};
        vecs[6] = '{5'd30, 32'h00C0_FFEE, 1'b1};
        vecs[7] = '{5'd2,  32'h8000_0001, 1'b1};

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        chk_0_addr = '0; chk_1_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    32'(write_en),   32'd0);
        check("rst_waddr", 32'(write_addr), 32'd0);
        check("rst_wdata", write_data,      32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU path, one result per cycle, FIFO empty
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1'b1;
            alu_addr  = vecs[i].addr;
            alu_data  = vecs[i].data;
            #1;
            check("alu_ready", 32'(alu_ready), 32'd1);
            if (vecs[i].exp_we) expect_wr(vecs[i].addr, vecs[i].data);
            tick();
            check("alu_we", 32'(write_en), 32'(vecs[i].exp_we));
        end
        alu_valid = 1'b0;
        tick();
        check("idle_we", 32'(write_en), 32'd0);

        // LSU result with scoreboard tracking, no push bypass
        issue(5'd7);
        probe(5'd7, 5'd7);
        check("busy7_q0", 32'(chk_0_busy), 32'd1);
        check("busy7_q1", 32'(chk_1_busy), 32'd1);
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hDEAD_BEEF;
        #1;
        check("lsu_ready", 32'(lsu_ready), 32'd1);
        expect_wr(5'd7, 32'hDEAD_BEEF);
        tick();
        lsu_valid = 1'b0;
        check("lsu_nobypass_we", 32'(write_en),   32'd0);
        check("lsu_count1",      32'(fifo_count), 32'd1);
        check("busy7_wait",      32'(chk_0_busy), 32'd1);
        tick();
        check("lsu_we",     32'(write_en),   32'd1);
        check("lsu_count0", 32'(fifo_count), 32'd0);
        check("busy7_done", 32'(chk_0_busy), 32'd0);

        // Streamed LSU results: push and pop in the same cycle keep count at 1
        for (int k = 0; k < 3; k++) begin
            lsu_valid = 1'b1;
            lsu_addr  = 5'(12 + k);
            lsu_data  = 32'h5000_0000 + 32'(k);
            expect_wr(lsu_addr, lsu_data);
            tick();
            check("stream_count", 32'(fifo_count), 32'd1);
            check("stream_we",    32'(write_en),   32'(k != 0));
        end
        lsu_valid = 1'b0;
        tick();
        check("stream_last_we", 32'(write_en),   32'd1);
        check("stream_count0",  32'(fifo_count), 32'd0);

        // Full FIFO: forced pop beats a waiting ALU result
        issue(5'd3);
        issue(5'd4);
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hA1A1_A1A1;
        lsu_valid = 1'b1; lsu_addr = 5'd3;  lsu_data = 32'h3333_3333;
        expect_wr(5'd20, 32'hA1A1_A1A1);
        tick();
        alu_addr = 5'd21; alu_data = 32'hA2A2_A2A2;
        lsu_addr = 5'd4;  lsu_data = 32'h4444_4444;
        expect_wr(5'd21, 32'hA2A2_A2A2);
        tick();
        lsu_valid = 1'b0;
        alu_addr = 5'd22; alu_data = 32'hA3A3_A3A3;
        #1;
        check("full_count",     32'(fifo_count), 32'd2);
        check("full_alu_ready", 32'(alu_ready),  32'd0);
        check("full_lsu_ready", 32'(lsu_ready),  32'd0);
        expect_wr(5'd3, 32'h3333_3333);
        tick();
        probe(5'd3, 5'd4);
        check("busy3_cleared", 32'(chk_0_busy), 32'd0);
        check("busy4_held",    32'(chk_1_busy), 32'd1);
        check("held_alu_ready", 32'(alu_ready), 32'd1);
        expect_wr(5'd22, 32'hA3A3_A3A3);
        tick();
        alu_valid = 1'b0;
        expect_wr(5'd4, 32'h4444_4444);
        tick();
        probe(5'd3, 5'd4);
        check("full_drained", 32'(fifo_count), 32'd0);
        check("busy4_cleared", 32'(chk_1_busy), 32'd0);

        // Register 0 from the LSU is consumed without a write; pending[0] stays 0
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        lsu_valid = 1'b0; issue_en = 1'b0;
        probe(5'd0, 5'd0);
        check("a0_count1", 32'(fifo_count), 32'd1);
        check("busy0",     32'(chk_0_busy), 32'd0);
        tick();
        check("a0_we",     32'(write_en),   32'd0);
        check("a0_count0", 32'(fifo_count), 32'd0);

        // Set/clear race on the same register: set wins, write still happens
        issue(5'd9);
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h9999_0001;
        expect_wr(5'd9, 32'h9999_0001);
        tick();
        lsu_valid = 1'b0;
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        issue_en = 1'b0;
        probe(5'd9, 5'd9);
        check("race_we",    32'(write_en),   32'd1);
        check("race_busy9", 32'(chk_0_busy), 32'd1);
        lsu_valid = 1'b1; lsu_data = 32'h9999_0002;
        expect_wr(5'd9, 32'h9999_0002);
        tick();
        lsu_valid = 1'b0;
        tick();
        probe(5'd9, 5'd9);
        check("race_busy9_clr", 32'(chk_0_busy), 32'd0);

        // Reset while the FIFO holds two entries discards them
        issue(5'd10);
        issue(5'd11);
        alu_valid = 1'b1; alu_addr = 5'd25; alu_data = 32'hC1C1_C1C1;
        lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_data = 32'h1010_1010;
        expect_wr(5'd25, 32'hC1C1_C1C1);
        tick();
        alu_addr = 5'd26; alu_data = 32'hC2C2_C2C2;
        lsu_addr = 5'd11; lsu_data = 32'h1111_1111;
        expect_wr(5'd26, 32'hC2C2_C2C2);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        probe(5'd10, 5'd11);
        check("prerst_count",  32'(fifo_count), 32'd2);
        check("prerst_busy10", 32'(chk_0_busy), 32'd1);
        check("prerst_busy11", 32'(chk_1_busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst2_we",    32'(write_en),   32'd0);
        check("rst2_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 32; i++) begin
            probe(5'(i), 5'(31 - i));
            busy0_all[i]      = chk_0_busy;
            busy1_all[31 - i] = chk_1_busy;
        end
        check("rst2_busy_q0", busy0_all, 32'd0);
        check("rst2_busy_q1", busy1_all, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("postrst_we",    32'(write_en),   32'd0);
        check("postrst_count", 32'(fifo_count), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
